// File: rtl/down_counter_pkg.sv
// Shared types and default sizes for the down counter.
// Imported by the counter top level.
package down_counter_pkg;

    localparam int DC_WIDTH    = 8;
    localparam int DC_PS_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Prescaler: emits one tick every ps_reg+1 advancing cycles.
// A load captures the divider; clear restarts the count.
module tick_prescaler #(
    parameter int PS_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic                clear,
    input  logic                advance,
    output logic                tick
);

    logic [PS_WIDTH-1:0] ps_reg;
    logic [PS_WIDTH-1:0] ps_cnt;

    assign tick = advance && (ps_cnt == ps_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_reg <= '0;
            ps_cnt <= '0;
        end else if (load) begin
            ps_reg <= prescale;
            ps_cnt <= '0;
        end else if (clear || tick) begin
            ps_cnt <= '0;
        end else if (advance) begin
            ps_cnt <= ps_cnt + PS_WIDTH'(1);
        end
    end

endmodule

// File: rtl/down_counter.sv
// Loadable down counter with prescaled ticks, auto-reload
// and a registered one-cycle terminal-count pulse.
module down_counter
    import down_counter_pkg::*;
#(
    parameter int WIDTH    = DC_WIDTH,
    parameter int PS_WIDTH = DC_PS_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [WIDTH-1:0]    load_val,
    input  logic [PS_WIDTH-1:0] prescale,
    input  logic                reload_en,
    input  logic                enable,
    input  logic                stop,
    output logic [WIDTH-1:0]    out,
    output logic                busy,
    output logic                tc
);

    state_t           state;
    logic [WIDTH-1:0] reload_reg;
    logic             tick;

    tick_prescaler #(
        .PS_WIDTH(PS_WIDTH)
    ) u_ps (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .prescale(prescale),
        .clear   (stop),
        .advance ((state == RUN) && enable),
        .tick    (tick)
    );

    assign busy = (state == RUN);

    // Priority: load, then stop, then the prescaled tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            out        <= '0;
            reload_reg <= '0;
            tc         <= 1'b0;
        end else if (load) begin
            out        <= load_val;
            reload_reg <= load_val;
            tc         <= (load_val == '0);
            state      <= (load_val != '0) ? RUN : IDLE;
        end else if (stop) begin
            state <= IDLE;
            tc    <= 1'b0;
        end else if (tick) begin
            if (out == WIDTH'(1)) begin
                tc <= 1'b1;
                if (reload_en) begin
                    out <= reload_reg;
                end else begin
                    out   <= '0;
                    state <= IDLE;
                end
            end else begin
                tc <= 1'b0;
                if (out != '0)
                    out <= out - WIDTH'(1);
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_counter.sv
// Self-checking bench for down_counter: vector table,
// directed corner sequences and a randomized model run.
module tb_down_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic [7:0] prescale = '0;
    logic       reload_en = 1'b0;
    logic       enable = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] out;
    logic       busy;
    logic       tc;

    int total = 0;
    int bad = 0;

    // behavioural model state
    int m_out, m_reload, m_period, m_left;
    bit m_run, m_tc;

    typedef struct {
        bit ld;
        int lv;
        int ps;
        bit re;
        bit en;
        bit st;
        int e_out;
        bit e_busy;
        bit e_tc;
    } vec_t;

    vec_t vecs[17];

    down_counter dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .prescale (prescale),
        .reload_en(reload_en),
        .enable   (enable),
        .stop     (stop),
        .out      (out),
        .busy     (busy),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d at %0t",
                     name, got, exp, $time);
        end
    endtask

    task automatic drive(input bit ld, input int lv, input int ps,
                         input bit re, input bit en, input bit st);
        load      = ld;
        load_val  = 8'(lv);
        prescale  = 8'(ps);
        reload_en = re;
        enable    = en;
        stop      = st;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_out = 0; m_reload = 0; m_period = 1; m_left = 1;
        m_run = 0; m_tc = 0;
    endtask

    // One clock edge of the counter described as enabled-cycles-to-next-tick.
    task automatic model_step();
        if (load) begin
            m_out = int'(load_val);
            m_reload = m_out;
            m_period = int'(prescale) + 1;
            m_left = m_period;
            m_tc = (m_out == 0);
            m_run = (m_out != 0);
        end else if (stop) begin
            m_run = 0;
            m_left = m_period;
            m_tc = 0;
        end else if (m_run && enable) begin
            m_tc = 0;
            m_left = m_left - 1;
            if (m_left == 0) begin
                m_left = m_period;
                if (m_out == 1) begin
                    m_tc = 1;
                    if (reload_en) m_out = m_reload;
                    else begin
                        m_out = 0;
                        m_run = 0;
                    end
                end else begin
                    m_out = m_out - 1;
                end
            end
        end else begin
            m_tc = 0;
        end
    endtask

    initial begin
        int en_cnt;
        bit seen;

        // 5,4,3,2,1,0 countdown, then enable ignored in IDLE
        vecs[0]  = '{1, 5, 0, 0, 1, 0, 5, 1, 0};
        vecs[1]  = '{0, 0, 0, 0, 1, 0, 4, 1, 0};
        vecs[2]  = '{0, 0, 0, 0, 1, 0, 3, 1, 0};
        vecs[3]  = '{0, 0, 0, 0, 1, 0, 2, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 1, 1, 0};
        vecs[5]  = '{0, 0, 0, 0, 1, 0, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        // load 6, stop at 3, then zero load
        vecs[7]  = '{1, 6, 0, 0, 1, 0, 6, 1, 0};
        vecs[8]  = '{0, 0, 0, 0, 1, 0, 5, 1, 0};
        vecs[9]  = '{0, 0, 0, 0, 1, 0, 4, 1, 0};
        vecs[10] = '{0, 0, 0, 0, 1, 0, 3, 1, 0};
        vecs[11] = '{0, 0, 0, 0, 1, 1, 3, 0, 0};
        vecs[12] = '{0, 0, 0, 0, 1, 0, 3, 0, 0};
        vecs[13] = '{0, 0, 0, 0, 1, 0, 3, 0, 0};
        vecs[14] = '{1, 0, 0, 0, 0, 0, 0, 0, 1};
        vecs[15] = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[16] = '{0, 0, 0, 0, 1, 0, 0, 0, 0};

        // reset state, then idle until the first load
        drive(0, 0, 0, 0, 1, 0);
        step();
        check("rst_out", int'(out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_tc", int'(tc), 0);
        rst = 1'b1;
        step();
        step();
        check("idle_out", int'(out), 0);
        check("idle_busy", int'(busy), 0);

        foreach (vecs[i]) begin
            drive(vecs[i].ld, vecs[i].lv, vecs[i].ps,
                  vecs[i].re, vecs[i].en, vecs[i].st);
            step();
            check($sformatf("vec%0d_out", i), int'(out), vecs[i].e_out);
            check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].e_busy));
            check($sformatf("vec%0d_tc", i), int'(tc), int'(vecs[i].e_tc));
        end

        // prescale 2: one decrement every 3 cycles, tc 9 cycles after load
        drive(1, 3, 2, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 1, 0);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("ps2_out_k%0d", k), int'(out), 3 - k / 3);
            check($sformatf("ps2_tc_k%0d", k), int'(tc), (k == 9) ? 1 : 0);
        end
        check("ps2_busy_end", int'(busy), 0);

        // auto-reload 2,1,2,1 with tc every 2 cycles
        drive(1, 2, 0, 1, 1, 0);
        step();
        drive(0, 0, 0, 1, 1, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check($sformatf("rl_out_k%0d", k), int'(out), (k % 2 == 1) ? 1 : 2);
            check($sformatf("rl_tc_k%0d", k), int'(tc), (k % 2 == 0) ? 1 : 0);
            check($sformatf("rl_busy_k%0d", k), int'(busy), 1);
        end
        drive(0, 0, 0, 0, 0, 1);
        step();
        check("rl_stop_busy", int'(busy), 0);

        // enable gating: 1,0,0 pattern, four enabled cycles to tc
        drive(1, 4, 0, 0, 1, 0);
        step();
        en_cnt = 0;
        seen = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            drive(0, 0, 0, 0, (k % 3 == 0), 0);
            if (k % 3 == 0) en_cnt++;
            step();
            check($sformatf("en_out_k%0d", k), int'(out), 4 - en_cnt);
            check($sformatf("en_tc_k%0d", k), int'(tc), (en_cnt == 4) ? 1 : 0);
            if (tc) seen = 1;
        end
        check("en_tc_seen", int'(seen), 1);
        check("en_cycles_to_tc", en_cnt, 4);

        // asynchronous reset mid-countdown
        drive(1, 5, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 1, 0);
        step();
        step();
        step();
        check("ar_pre_out", int'(out), 2);
        #3 rst = 1'b0;
        #1;
        check("ar_out", int'(out), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_tc", int'(tc), 0);
        step();
        rst = 1'b1;
        step();
        check("ar_after_out", int'(out), 0);
        check("ar_after_tc", int'(tc), 0);
        check("ar_after_busy", int'(busy), 0);

        // load on the terminal tick wins and suppresses tc
        drive(1, 3, 0, 0, 1, 0);
        step();
        drive(0, 0, 0, 0, 1, 0);
        step();
        step();
        check("lt_pre_out", int'(out), 1);
        drive(1, 7, 0, 0, 1, 0);
        step();
        check("lt_out", int'(out), 7);
        check("lt_tc", int'(tc), 0);
        check("lt_busy", int'(busy), 1);

        // randomized run against the model
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        model_reset();
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 11) == 0,
                  ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6)),
                  $urandom_range(0, 3),
                  $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0);
            step();
            model_step();
            check($sformatf("rnd%0d_out", n), int'(out), m_out);
            check($sformatf("rnd%0d_busy", n), int'(busy), int'(m_run));
            check($sformatf("rnd%0d_tc", n), int'(tc), int'(m_tc));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_counter.md
DOWN_COUNTER -- requirements
Module: down_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of count, load value and reload register.
REQ-002 SHALL have parameter PS_WIDTH, default 8: bit width of the prescale value.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on posedge clk.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-low reset (rst=0 resets).
REQ-005 SHALL have port load, input, 1 bit: one-cycle pulse that starts or restarts a countdown.
REQ-006 SHALL have port load_val, input, WIDTH bits: start value, sampled when load=1.
REQ-007 SHALL have port prescale, input, PS_WIDTH bits: tick divider, sampled when load=1.
REQ-008 SHALL have port reload_en, input, 1 bit: auto-reload mode, sampled at each terminal tick.
REQ-009 SHALL have port enable, input, 1 bit: count advances only while 1.
REQ-010 SHALL have port stop, input, 1 bit: abort to IDLE.
REQ-011 SHALL have port out, output, WIDTH bits: current count, registered.
REQ-012 SHALL have port busy, output, 1 bit: 1 while in RUN.
REQ-013 SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, RUN.
REQ-015 On load=1 in any state, SHALL capture out<=load_val, reload_reg<=load_val, ps_reg<=prescale, ps_cnt<=0; next state RUN if load_val!=0.
REQ-016 If load=1 with load_val==0, SHALL set out=0, pulse tc for the next cycle, and go to or remain in IDLE.
REQ-017 In RUN with enable=1, SHALL increment ps_cnt each cycle; when ps_cnt==ps_reg, SHALL assert an internal tick, clear ps_cnt, and decrement out by 1.
REQ-018 With ps_reg=0, a tick SHALL occur on every enabled cycle, giving a countdown of N taking N enabled cycles; in general a tick occurs every ps_reg+1 enabled cycles.
REQ-019 With enable=0, out and ps_cnt SHALL hold, and the FSM SHALL stay in RUN.
REQ-020 On a tick with out==1 and reload_en=0, SHALL set out<=0, tc<=1, and state<=IDLE.
REQ-021 On a tick with out==1 and reload_en=1, SHALL set out<=reload_reg, tc<=1, and remain in RUN; out never shows 0 in this mode.
REQ-022 tc SHALL be high for exactly one cycle per terminal tick and 0 otherwise.
REQ-023 stop=1 SHALL go to IDLE, hold out, clear ps_cnt, and assert no tc.
REQ-024 Priority when simultaneous SHALL be load > stop > tick; a load coinciding with a terminal tick SHALL suppress that tc.
REQ-025 In IDLE, out SHALL hold its value and enable SHALL be ignored.
REQ-026 out SHALL never wrap below 0; all arithmetic is unsigned, modulo WIDTH/PS_WIDTH only where unreachable.

Reset
REQ-027 While rst=0, SHALL asynchronously force state=IDLE, out=0, reload_reg=0, ps_reg=0, ps_cnt=0, tc=0, busy=0.
REQ-028 Reset asserted mid-countdown SHALL abort immediately with no tc pulse.
REQ-029 After rst deasserts, the block SHALL remain in IDLE until the first load.

Structure
REQ-030 Package down_counter_pkg SHALL hold the FSM state enum (IDLE, RUN) and the default WIDTH/PS_WIDTH constants.
REQ-031 The prescaler (ps_reg, ps_cnt, tick generation, clear input) SHALL be a sub-module named tick_prescaler; the FSM, count and tc logic stay in down_counter.

Verification
REQ-032 load_val=5, prescale=0, enable=1, reload_en=0 -> out 5,4,3,2,1,0 on consecutive cycles; tc=1 with out=0; busy falls the same cycle.
REQ-033 load_val=3, prescale=2, enable=1 -> out decrements every 3 cycles; tc 9 cycles after load.
REQ-034 load_val=2, prescale=0, reload_en=1 -> out 2,1,2,1,...; tc pulses every 2 cycles; busy stays 1.
REQ-035 load_val=4 with enable toggled 1,0,0,1,... -> out holds during enable=0; total enabled cycles to tc = 4.
REQ-036 load_val=6, stop at out=3 -> out stays 3, busy=0, no tc; then load=1 with load_val=0 -> out=0, single tc pulse, IDLE.
REQ-037 rst=0 asserted asynchronously (between clock edges) at out=2 -> out=0 and busy=0 immediately, no tc; load coinciding with a terminal tick -> new value loaded, no tc.
